agc_sar_sequencer: RTL and testbench

Successive-approximation gain acquisition controller for the receive AGC chain. It drives a 6-bit gain code, MSB first, into the gain mapping function (VGA1/2/3 split). Each trial gain gets a settle window, then an overload-observation window, then a keep/clear decision per bit. After lock it monitors sustained overload and re-acquires on its own.

---
 rtl/agc_sar_sequencer_if.sv | 43 ++++
 rtl/agc_sar_sequencer.sv | 168 ++++++++++++++++
 tb/tb_agc_sar_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/agc_sar_sequencer_if.sv
// rtl/agc_sar_sequencer_if.sv - control/status bundle between AGC front-end logic and the SAR gain sequencer
interface agc_sar_sequencer_if #(
    parameter int GAIN_W = 6
) ();
    // Inputs to the sequencer
    logic              enable;
    logic              start;
    logic              freeze;
    logic              overload;

    // Outputs from the sequencer
    logic [GAIN_W-1:0] gain_code;
    logic              gain_valid;
    logic              busy;
    logic              locked;
    logic              reacq;

    // Front-end side: issues enable/start/freeze and reports ADC overload
    modport master (
        output enable,
        output start,
        output freeze,
        output overload,
        input  gain_code,
        input  gain_valid,
        input  busy,
        input  locked,
        input  reacq
    );

    // Sequencer side
    modport slave (
        input  enable,
        input  start,
        input  freeze,
        input  overload,
        output gain_code,
        output gain_valid,
        output busy,
        output locked,
        output reacq
    );
endinterface

// File: rtl/agc_sar_sequencer.sv
// rtl/agc_sar_sequencer.sv - successive-approximation AGC gain acquisition with overload-driven re-acquisition
module agc_sar_sequencer #(
    parameter int GAIN_W     = 6,
    parameter int SETTLE_CYC = 4,
    parameter int OBS_CYC    = 8,
    parameter int OVLD_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  RESET,
    agc_sar_sequencer_if.slave    sif
);

    localparam int BIT_W = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;

    localparam logic [BIT_W-1:0]  BIT_MSB     = BIT_W'(GAIN_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE     = BIT_W'(1);
    localparam logic [GAIN_W-1:0] MSB_CODE    = GAIN_W'(1) << (GAIN_W - 1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]        OBS_LAST    = 8'(OBS_CYC - 1);
    localparam logic [7:0]        OVLD_LAST   = 8'(OVLD_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_OBSERVE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    state_t              state_q,      state_d;
    logic [7:0]          cnt_q,        cnt_d;
    logic [BIT_W-1:0]    bit_q,        bit_d;
    logic                seen_q,       seen_d;
    logic [7:0]          ovld_cnt_q,   ovld_cnt_d;
    logic [GAIN_W-1:0]   gain_q,       gain_d;
    logic                gain_valid_q, gain_valid_d;
    logic                reacq_q,      reacq_d;
    logic                restart;

    // Next-state logic: enable gates everything, start (or a LOCKED overload burst) restarts the search
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        seen_d       = seen_q;
        ovld_cnt_d   = ovld_cnt_q;
        gain_d       = gain_q;
        gain_valid_d = 1'b0;
        reacq_d      = 1'b0;
        restart      = 1'b0;

        if (!sif.enable) begin
            // Gain is deliberately held so the analog chain is not disturbed
            state_d    = ST_IDLE;
            cnt_d      = 8'd0;
            seen_d     = 1'b0;
            ovld_cnt_d = 8'd0;
            bit_d      = BIT_MSB;
        end else if (sif.start) begin
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_SETTLE: begin
                    // Overload is meaningless while the VGA/ADC are still settling
                    if (!sif.freeze) begin
                        if (cnt_q == SETTLE_LAST) begin
                            state_d = ST_OBSERVE;
                            cnt_d   = 8'd0;
                            seen_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end

                ST_OBSERVE: begin
                    if (!sif.freeze) begin
                        seen_d = seen_q | sif.overload;
                        if (cnt_q == OBS_LAST) begin
                            state_d = ST_DECIDE;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end

                ST_DECIDE: begin
                    // Keep the trial bit only if the observation window stayed clean
                    gain_d[bit_q] = ~seen_q;
                    if (bit_q != '0) begin
                        gain_d[bit_q - BIT_ONE] = 1'b1;
                        bit_d                   = bit_q - BIT_ONE;
                        state_d                 = ST_SETTLE;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                    ovld_cnt_d   = 8'd0;
                    gain_valid_d = (gain_d != gain_q);
                end

                ST_LOCKED: begin
                    // Only an unbroken run of overload cycles triggers re-acquisition
                    if (!sif.freeze) begin
                        if (sif.overload) begin
                            if (ovld_cnt_q == OVLD_LAST) begin
                                restart = 1'b1;
                                reacq_d = 1'b1;
                            end else begin
                                ovld_cnt_d = ovld_cnt_q + 8'd1;
                            end
                        end else begin
                            ovld_cnt_d = 8'd0;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Shared entry into the MSB trial; earlier results are discarded
        if (restart) begin
            state_d      = ST_SETTLE;
            cnt_d        = 8'd0;
            seen_d       = 1'b0;
            bit_d        = BIT_MSB;
            ovld_cnt_d   = 8'd0;
            gain_d       = MSB_CODE;
            gain_valid_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            bit_q        <= BIT_MSB;
            seen_q       <= 1'b0;
            ovld_cnt_q   <= 8'd0;
            gain_q       <= '0;
            gain_valid_q <= 1'b0;
            reacq_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            seen_q       <= seen_d;
            ovld_cnt_q   <= ovld_cnt_d;
            gain_q       <= gain_d;
            gain_valid_q <= gain_valid_d;
            reacq_q      <= reacq_d;
        end
    end

    assign sif.gain_code  = gain_q;
    assign sif.gain_valid = gain_valid_q;
    assign sif.busy       = (state_q == ST_SETTLE) || (state_q == ST_OBSERVE) || (state_q == ST_DECIDE);
    assign sif.locked     = (state_q == ST_LOCKED);
    assign sif.reacq      = reacq_q;

endmodule

// File: tb/tb_agc_sar_sequencer.sv
// tb/tb_agc_sar_sequencer.sv - directed self-checking bench for agc_sar_sequencer
module tb_agc_sar_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    agc_sar_sequencer_if #(.GAIN_W(6)) sif ();

    agc_sar_sequencer #(
        .GAIN_W    (6),
        .SETTLE_CYC(4),
        .OBS_CYC   (8),
        .OVLD_LIMIT(4)
    ) dut (
        .clk  (clk),
        .RESET(rst),
        .sif  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overload environment: 0 never, 1 always, 2 gain_code>thr, 3 only in SETTLE windows
    typedef struct {
        int mode;
        int thr;
        int frz_k;
        int frz_len;
        int exp_gain;
        int exp_cyc;
        int exp_pulses;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sif.enable   = 1'b0;
        sif.start    = 1'b0;
        sif.freeze   = 1'b0;
        sif.overload = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_acq();
        sif.enable = 1'b1;
        sif.start  = 1'b1;
        tick();
        sif.start  = 1'b0;
    endtask

    function automatic logic ovl_for(input int mode, input int thr, input int k, input logic [5:0] g);
        int j;
        j = ((k - 1) % 13) + 1;
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (int'(g) > thr);
            3:       return (j <= 4);
            default: return 1'b0;
        endcase
    endfunction

    // Runs edges after the start edge until locked; freeze window forces overload high to prove it is ignored
    task automatic run_to_lock(input int mode, input int thr, input int frz_k, input int frz_len,
                               output int cyc, output int pulses, output logic [5:0] final_g);
        logic frozen;
        cyc    = 0;
        pulses = sif.gain_valid ? 1 : 0;
        for (int k = 1; k <= 400; k++) begin
            frozen       = (k >= frz_k) && (k < frz_k + frz_len);
            sif.freeze   = frozen;
            sif.overload = frozen ? 1'b1 : ovl_for(mode, thr, k, sif.gain_code);
            tick();
            if (sif.gain_valid) pulses++;
            if (sif.locked) begin
                cyc = k;
                break;
            end
        end
        sif.freeze   = 1'b0;
        sif.overload = 1'b0;
        final_g      = sif.gain_code;
    endtask

    initial begin
        int          cyc;
        int          pulses;
        int          nreacq;
        logic [5:0]  fg;
        logic [7:0]  pat;

        tests = 0;
        fails = 0;

        vecs[0] = '{mode: 0, thr: 0,  frz_k: 0,  frz_len: 0,  exp_gain: 63, exp_cyc: 78, exp_pulses: 6};
        vecs[1] = '{mode: 1, thr: 0,  frz_k: 0,  frz_len: 0,  exp_gain: 0,  exp_cyc: 78, exp_pulses: 7};
        vecs[2] = '{mode: 2, thr: 45, frz_k: 0,  frz_len: 0,  exp_gain: 45, exp_cyc: 78, exp_pulses: 6};
        vecs[3] = '{mode: 3, thr: 0,  frz_k: 0,  frz_len: 0,  exp_gain: 63, exp_cyc: 78, exp_pulses: 6};
        vecs[4] = '{mode: 2, thr: 31, frz_k: 0,  frz_len: 0,  exp_gain: 31, exp_cyc: 78, exp_pulses: 6};
        vecs[5] = '{mode: 2, thr: 45, frz_k: 31, frz_len: 10, exp_gain: 45, exp_cyc: 88, exp_pulses: 6};

        do_reset();
        check("rst_gain",       32'(sif.gain_code),  32'd0);
        check("rst_gain_valid", 32'(sif.gain_valid), 32'd0);
        check("rst_busy",       32'(sif.busy),       32'd0);
        check("rst_locked",     32'(sif.locked),     32'd0);
        check("rst_reacq",      32'(sif.reacq),      32'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            start_acq();
            check($sformatf("v%0d_first_trial", i), 32'(sif.gain_code),  32'd32);
            check($sformatf("v%0d_first_valid", i), 32'(sif.gain_valid), 32'd1);
            check($sformatf("v%0d_first_busy", i),  32'(sif.busy),       32'd1);
            run_to_lock(vecs[i].mode, vecs[i].thr, vecs[i].frz_k, vecs[i].frz_len, cyc, pulses, fg);
            check($sformatf("v%0d_lock_cycles", i), 32'(cyc),    32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_final_gain", i),  32'(fg),     32'(vecs[i].exp_gain));
            check($sformatf("v%0d_valid_count", i), 32'(pulses), 32'(vecs[i].exp_pulses));
        end

        // LOCKED at 45: broken overload runs must not trigger
        pat    = 8'b0111_0111;
        nreacq = 0;
        for (int i = 0; i < 8; i++) begin
            sif.overload = pat[i];
            tick();
            if (sif.reacq) nreacq++;
        end
        check("lock_broken_runs_reacq", 32'(nreacq),        32'd0);
        check("lock_broken_runs_lock",  32'(sif.locked),    32'd1);
        check("lock_broken_runs_gain",  32'(sif.gain_code), 32'd45);

        // Four consecutive overload cycles force re-acquisition
        nreacq = 0;
        for (int i = 0; i < 3; i++) begin
            sif.overload = 1'b1;
            tick();
            if (sif.reacq) nreacq++;
        end
        check("reacq_early", 32'(nreacq), 32'd0);
        sif.overload = 1'b1;
        tick();
        check("reacq_pulse",  32'(sif.reacq),      32'd1);
        check("reacq_locked", 32'(sif.locked),     32'd0);
        check("reacq_gain",   32'(sif.gain_code),  32'd32);
        check("reacq_busy",   32'(sif.busy),       32'd1);
        check("reacq_valid",  32'(sif.gain_valid), 32'd1);
        sif.overload = 1'b0;
        tick();
        check("reacq_one_cycle", 32'(sif.reacq), 32'd0);

        // start beats the overload trigger in the same cycle
        do_reset();
        start_acq();
        run_to_lock(2, 45, 0, 0, cyc, pulses, fg);
        check("sbt_locked_gain", 32'(fg), 32'd45);
        for (int i = 0; i < 3; i++) begin
            sif.overload = 1'b1;
            tick();
        end
        sif.overload = 1'b1;
        sif.start    = 1'b1;
        tick();
        sif.start    = 1'b0;
        sif.overload = 1'b0;
        check("sbt_no_reacq", 32'(sif.reacq),     32'd0);
        check("sbt_gain",     32'(sif.gain_code), 32'd32);
        check("sbt_busy",     32'(sif.busy),      32'd1);
        check("sbt_locked",   32'(sif.locked),    32'd0);

        // start mid-search during the bit-2 trial restarts at 32
        do_reset();
        start_acq();
        for (int k = 1; k <= 45; k++) tick();
        check("mid_bit2_gain", 32'(sif.gain_code), 32'd60);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        check("mid_restart_gain",  32'(sif.gain_code),  32'd32);
        check("mid_restart_valid", 32'(sif.gain_valid), 32'd1);
        run_to_lock(0, 0, 0, 0, cyc, pulses, fg);
        check("mid_restart_cycles", 32'(cyc), 32'd78);
        check("mid_restart_final",  32'(fg),  32'd63);

        // enable dropped mid-OBSERVE
        do_reset();
        start_acq();
        for (int k = 1; k <= 6; k++) tick();
        sif.enable = 1'b0;
        tick();
        check("en_drop_busy",   32'(sif.busy),      32'd0);
        check("en_drop_locked", 32'(sif.locked),    32'd0);
        check("en_drop_gain",   32'(sif.gain_code), 32'd32);
        sif.start = 1'b1;
        tick();
        sif.start = 1'b0;
        check("en_low_start_busy",  32'(sif.busy),       32'd0);
        check("en_low_start_valid", 32'(sif.gain_valid), 32'd0);

        // RESET mid-SETTLE
        do_reset();
        start_acq();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_gain",   32'(sif.gain_code),  32'd0);
        check("rst_mid_valid",  32'(sif.gain_valid), 32'd0);
        check("rst_mid_busy",   32'(sif.busy),       32'd0);
        check("rst_mid_locked", 32'(sif.locked),     32'd0);
        check("rst_mid_reacq",  32'(sif.reacq),      32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
